// File: rtl/fifo_mailbox_pkg.sv
// Shared constants and address decode for the multi-channel OBI FIFO mailbox.
// Status word layout, control word layout and the channel/region split of an address.
package fifo_mailbox_pkg;

    localparam int unsigned USAGE_LSB  = 0;
    localparam int unsigned EMPTY_BIT  = 16;
    localparam int unsigned FULL_BIT   = 17;
    localparam int unsigned IRQ_BIT    = 18;
    localparam int unsigned FLUSH_BIT  = 0;

    localparam int unsigned DEC_ADDR_W = 64;
    localparam int unsigned MAX_CH_W   = 5;

    typedef struct packed {
        logic                region;
        logic [MAX_CH_W-1:0] ch;
    } addr_dec_t;

    // Word address bits [2 +: ch_w] select the channel; the next bit up selects data (0) or status (1).
    function automatic addr_dec_t decode_addr(input logic [DEC_ADDR_W-1:0] addr,
                                              input int unsigned           ch_w);
        addr_dec_t             dec;
        logic [DEC_ADDR_W-1:0] mask;
        mask       = (DEC_ADDR_W'(1) << ch_w) - DEC_ADDR_W'(1);
        dec.ch     = MAX_CH_W'((addr >> 2) & mask);
        dec.region = 1'((addr >> (ch_w + 2)));
        return dec;
    endfunction

endpackage

// File: rtl/fifo_v3.sv
// Single-clock word FIFO with synchronous flush; usage wraps to 0 when full (full_o disambiguates).
// Flush takes priority over a same-cycle push or pop; a same-cycle pop still sees the current head.
module fifo_v3 #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned ADDR_DEPTH = $clog2(DEPTH)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    input  logic                  testmode_i,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [ADDR_DEPTH-1:0] usage_o,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  push_i,
    output logic [DATA_WIDTH-1:0] data_o,
    input  logic                  pop_i
);

    localparam logic [ADDR_DEPTH:0] FULL_CNT = (ADDR_DEPTH + 1)'(DEPTH);

    logic [ADDR_DEPTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_DEPTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_DEPTH:0]   cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic                  do_push, do_pop;
    logic                  unused_testmode;

    assign unused_testmode = testmode_i;

    assign full_o  = (cnt_q == FULL_CNT);
    assign empty_o = (cnt_q == '0);
    assign usage_o = cnt_q[ADDR_DEPTH-1:0];
    assign data_o  = mem_q[rd_ptr_q];
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        cnt_d    = cnt_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + ADDR_DEPTH'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + ADDR_DEPTH'(1);
            case ({do_push, do_pop})
                2'b10:   cnt_d = cnt_q + (ADDR_DEPTH + 1)'(1);
                2'b01:   cnt_d = cnt_q - (ADDR_DEPTH + 1)'(1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage needs no reset: the pointers/count decide what is readable.
    always_ff @(posedge clk_i) begin
        if (do_push && !flush_i) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/fifo_mailbox_mc.sv
// Multi-channel OBI FIFO mailbox: writer port pushes/flushes per channel, reader port pops or reads status.
// Per-channel level interrupt when usage reaches IRQ_THRESHOLD.
module fifo_mailbox_mc
    import fifo_mailbox_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned ADDR_WIDTH    = 32,
    parameter int unsigned FIFO_DEPTH    = 8,
    parameter int unsigned NUM_CH        = 4,
    parameter int unsigned IRQ_THRESHOLD = 6
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  writer_req_i,
    output logic                  writer_gnt_o,
    output logic                  writer_rvalid_o,
    input  logic [ADDR_WIDTH-1:0] writer_addr_i,
    input  logic                  writer_we_i,
    input  logic [3:0]            writer_be_i,
    input  logic [DATA_WIDTH-1:0] writer_wdata_i,
    output logic [DATA_WIDTH-1:0] writer_rdata_o,
    input  logic                  reader_req_i,
    output logic                  reader_gnt_o,
    output logic                  reader_rvalid_o,
    input  logic [ADDR_WIDTH-1:0] reader_addr_i,
    input  logic                  reader_we_i,
    input  logic [3:0]            reader_be_i,
    input  logic [DATA_WIDTH-1:0] reader_wdata_i,
    output logic [DATA_WIDTH-1:0] reader_rdata_o,
    output logic [NUM_CH-1:0]     irq_o
);

    localparam int unsigned CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
    localparam int unsigned USAGE_W = PTR_W + 1;

    // Handshake: a transaction is accepted on a cycle with req & gnt; rvalid is high exactly
    // one cycle later for one cycle, so back-to-back acceptances give back-to-back rvalids.
    // gnt is combinational and only drops for a push to a full or a pop from an empty channel.

    addr_dec_t             w_dec, r_dec;
    logic [CH_W-1:0]       w_ch, r_ch;
    logic                  w_push_acc, w_ctrl_acc, r_pop_acc, r_acc;
    logic [NUM_CH-1:0]     full, empty, push, pop, flush, irq;
    logic [PTR_W-1:0]      fifo_usage [NUM_CH];
    logic [USAGE_W-1:0]    usage [NUM_CH];
    logic [DATA_WIDTH-1:0] head [NUM_CH];
    logic                  writer_rvalid_q, reader_rvalid_q;
    logic [DATA_WIDTH-1:0] reader_rdata_q, reader_rdata_d;
    logic                  unused_ok;

    assign w_dec = decode_addr(DEC_ADDR_W'(writer_addr_i), CH_W);
    assign r_dec = decode_addr(DEC_ADDR_W'(reader_addr_i), CH_W);
    assign w_ch  = w_dec.ch[CH_W-1:0];
    assign r_ch  = r_dec.ch[CH_W-1:0];

    assign unused_ok = ^{w_dec, r_dec, writer_be_i, reader_be_i, reader_wdata_i};

    always_comb begin
        writer_gnt_o = 1'b1;
        if (writer_we_i && !w_dec.region) writer_gnt_o = ~full[w_ch];
    end

    always_comb begin
        reader_gnt_o = 1'b1;
        if (!reader_we_i && !r_dec.region) reader_gnt_o = ~empty[r_ch];
    end

    assign w_push_acc = writer_req_i & writer_gnt_o & writer_we_i & ~w_dec.region;
    assign w_ctrl_acc = writer_req_i & writer_gnt_o & writer_we_i &  w_dec.region;
    assign r_acc      = reader_req_i & reader_gnt_o;
    assign r_pop_acc  = r_acc & ~reader_we_i & ~r_dec.region;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        assign push[c]  = w_push_acc && (w_ch == CH_W'(c));
        assign flush[c] = w_ctrl_acc && writer_wdata_i[FLUSH_BIT] && (w_ch == CH_W'(c));
        assign pop[c]   = r_pop_acc && (r_ch == CH_W'(c));

        fifo_v3 #(
            .DATA_WIDTH (DATA_WIDTH),
            .DEPTH      (FIFO_DEPTH)
        ) u_fifo (
            .clk_i      (clk_i),
            .rst_ni     (rst_ni),
            .flush_i    (flush[c]),
            .testmode_i (1'b0),
            .full_o     (full[c]),
            .empty_o    (empty[c]),
            .usage_o    (fifo_usage[c]),
            .data_i     (writer_wdata_i),
            .push_i     (push[c]),
            .data_o     (head[c]),
            .pop_i      (pop[c])
        );

        // fifo_v3 usage wraps to zero at full depth.
        assign usage[c] = full[c] ? USAGE_W'(FIFO_DEPTH) : {1'b0, fifo_usage[c]};
        assign irq[c]   = (usage[c] >= USAGE_W'(IRQ_THRESHOLD));
    end

    function automatic logic [DATA_WIDTH-1:0] status_word(input logic [USAGE_W-1:0] u,
                                                          input logic e,
                                                          input logic f,
                                                          input logic i);
        logic [DATA_WIDTH-1:0] s;
        s                   = '0;
        s[USAGE_LSB +: 16]  = 16'(u);
        s[EMPTY_BIT]        = e;
        s[FULL_BIT]         = f;
        s[IRQ_BIT]          = i;
        return s;
    endfunction

    always_comb begin
        reader_rdata_d = reader_rdata_q;
        if (r_acc) begin
            if (reader_we_i)       reader_rdata_d = '0;
            else if (!r_dec.region) reader_rdata_d = head[r_ch];
            else                   reader_rdata_d = status_word(usage[r_ch], empty[r_ch],
                                                                full[r_ch], irq[r_ch]);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            writer_rvalid_q <= 1'b0;
            reader_rvalid_q <= 1'b0;
            reader_rdata_q  <= '0;
        end else begin
            writer_rvalid_q <= writer_req_i & writer_gnt_o;
            reader_rvalid_q <= r_acc;
            reader_rdata_q  <= reader_rdata_d;
        end
    end

    assign writer_rvalid_o = writer_rvalid_q;
    assign reader_rvalid_o = reader_rvalid_q;
    assign reader_rdata_o  = reader_rdata_q;
    assign writer_rdata_o  = '0;
    assign irq_o           = irq;

endmodule
